mlp_argmax: RTL and testbench

- Classification stage directly downstream of the MLP top.
- Consumes the NUM_CLASSES signed fixed-point scores and the MLP done pulse.
- Scans the scores sequentially, one class per cycle, and produces the winning class index, the winning score and the top-1/top-2 margin.
- Presents the result on a valid/ready output handshake, with overrun detection.

---
 rtl/mlp_pkg.sv | 38 +++
 rtl/mlp_argmax.sv | 147 ++++++++++++++
 tb/tb_mlp_argmax.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared fixed-point types, limits, FSM state encoding and saturating subtract
// for the MLP datapath and its argmax classification stage.
package mlp_pkg;

  localparam int unsigned FP_W = 16;

  typedef logic signed [FP_W-1:0] fp_t;

  localparam fp_t FP_MAX = 16'sh7FFF;
  localparam fp_t FP_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_e;

  // a - b clamped to [0, 2^(w-1)-1]; operands are w-bit values sign-extended
  // to 32 bits, so the difference never wraps for w <= 31.
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned       w);
    logic signed [31:0] diff;
    logic signed [31:0] lim;
    logic signed [31:0] res;
    diff = a - b;
    lim  = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (diff > lim) begin
      res = lim;
    end else if (diff < 32'sd0) begin
      res = '0;
    end else begin
      res = diff;
    end
    return res;
  endfunction

endpackage

// File: rtl/mlp_argmax.sv
// Sequential argmax over the MLP output scores: one class per cycle, reports
// winning index, winning score and saturated top-1/top-2 margin on valid/ready.
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_CLASSES   = 3,
  parameter int unsigned FP_TOTAL_BITS = 16,
  parameter int unsigned FP_FRAC_BITS  = 8,
  parameter int unsigned IDX_W         = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic signed [FP_TOTAL_BITS-1:0] scores [NUM_CLASSES],
  output logic        [IDX_W-1:0]         class_idx,
  output logic signed [FP_TOTAL_BITS-1:0] max_score,
  output logic signed [FP_TOTAL_BITS-1:0] margin,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            overrun,
  input  logic                            clear_overrun
);

  // Integer/fraction split is irrelevant to compare and subtract; it only
  // locates the sign bit.
  localparam int unsigned SIGN_BIT = FP_FRAC_BITS + (FP_TOTAL_BITS - FP_FRAC_BITS) - 1;

  typedef logic signed [FP_TOTAL_BITS-1:0] score_t;

  localparam score_t           S_MIN = score_t'({1'b1, {SIGN_BIT{1'b0}}});
  localparam score_t           S_MAX = ~S_MIN;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_CLASSES - 1);

  state_e           state_q, state_d;
  score_t           copy_q [NUM_CLASSES];
  score_t           copy_d [NUM_CLASSES];
  score_t           best_q, best_d;
  score_t           second_q, second_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] cls_q, cls_d;
  score_t           max_q, max_d;
  score_t           margin_q, margin_d;
  logic             overrun_q, overrun_d;

  score_t cand;
  logic   xfer;
  logic   accept;

  always_comb begin
    state_d    = state_q;
    copy_d     = copy_q;
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    i_d        = i_q;
    cls_d      = cls_q;
    max_d      = max_q;
    margin_d   = margin_q;

    cand   = copy_q[i_q];
    xfer   = (state_q == HOLD) && out_ready;
    accept = start && ((state_q == IDLE) || xfer);

    unique case (state_q)
      IDLE: begin
      end
      SCAN: begin
        if (cand > best_q) begin
          second_d   = best_q;
          best_d     = cand;
          best_idx_d = i_q;
        end else if (cand > second_q) begin
          second_d = cand;
        end
        if (i_q == LAST) begin
          state_d  = HOLD;
          cls_d    = best_idx_d;
          max_d    = best_d;
          margin_d = score_t'(sat_sub(32'(best_d), 32'(second_d), FP_TOTAL_BITS));
        end else begin
          i_d = i_q + IDX_W'(1);
        end
      end
      HOLD: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted start overrides the HOLD->IDLE return, giving back-to-back.
    if (accept) begin
      copy_d     = scores;
      best_d     = scores[0];
      second_d   = S_MIN;
      best_idx_d = '0;
      i_d        = IDX_W'(1);
      if (NUM_CLASSES == 1) begin
        state_d  = HOLD;
        cls_d    = '0;
        max_d    = scores[0];
        margin_d = S_MAX;
      end else begin
        state_d = SCAN;
      end
    end

    overrun_d = (start && !accept) || (overrun_q && !clear_overrun);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      copy_q     <= '{default: '0};
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
      i_q        <= '0;
      cls_q      <= '0;
      max_q      <= '0;
      margin_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      copy_q     <= copy_d;
      best_q     <= best_d;
      second_q   <= second_d;
      best_idx_q <= best_idx_d;
      i_q        <= i_d;
      cls_q      <= cls_d;
      max_q      <= max_d;
      margin_q   <= margin_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign class_idx = cls_q;
  assign max_score = max_q;
  assign margin    = margin_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mlp_argmax.sv
// Self-checking bench for mlp_argmax: directed test-plan cases plus randomized
// score vectors checked against a plain max/second-max reference model.
module tb_mlp_argmax;

  localparam int N = 3;
  localparam int W = 16;

  typedef logic signed [W-1:0] vec_t [N];

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             out_ready;
  logic             clear_overrun;
  vec_t             scores;
  logic [1:0]       class_idx;
  logic signed [W-1:0] max_score;
  logic signed [W-1:0] margin;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int e_idx, e_max, e_mg;

  always #5 clk = ~clk;

  mlp_argmax #(
    .NUM_CLASSES  (N),
    .FP_TOTAL_BITS(W),
    .FP_FRAC_BITS (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .scores       (scores),
    .class_idx    (class_idx),
    .max_score    (max_score),
    .margin       (margin),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Winner = first index holding the maximum; runner-up = max of all others.
  function automatic void model(input vec_t v);
    int s [N];
    int sec;
    for (int k = 0; k < N; k++) s[k] = int'(v[k]);
    e_idx = 0;
    for (int k = 1; k < N; k++) if (s[k] > s[e_idx]) e_idx = k;
    e_max = s[e_idx];
    sec = -100000;
    for (int k = 0; k < N; k++) if (k != e_idx && s[k] > sec) sec = s[k];
    e_mg = (N == 1) ? 32767 : e_max - sec;
    if (e_mg > 32767) e_mg = 32767;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k] = ($urandom_range(0, 1) == 0) ? 16'sh7FFF : 16'sh8000;
        1, 2:    v[k] = W'(($urandom_range(0, 4) - 2) * 256);
        default: v[k] = W'($urandom);
      endcase
    end
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic launch(input vec_t v);
    scores = v;
    model(v);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    scores = rand_vec();
  endtask

  task automatic expect_scan_then_hold(input string tag);
    check({tag, ".v0"}, 32'(out_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, ".v1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".idx"}, 32'(class_idx), 32'(e_idx));
    check({tag, ".max"}, 32'(max_score), 32'(e_max));
    check({tag, ".margin"}, 32'(margin), 32'(e_mg));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".done_v"}, 32'(out_valid), 32'd0);
    check({tag, ".done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t t;
    int   d;

    reset         = 1'b1;
    start         = 1'b0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    scores        = '{default: '0};
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.idx", 32'(class_idx), 32'd0);
    check("rst.max", 32'(max_score), 32'd0);
    check("rst.margin", 32'(margin), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    t = '{16'sh0100, 16'sh0300, 16'shFF00};
    launch(t); expect_scan_then_hold("basic"); drain("basic");
    check("basic.idx_k", 32'(e_idx), 32'd1);
    t = '{16'sh0200, 16'sh0200, 16'sh0100};
    launch(t); expect_scan_then_hold("tie"); drain("tie");
    t = '{16'shFE00, 16'shFF00, 16'shFD00};
    launch(t); expect_scan_then_hold("neg"); drain("neg");
    t = '{16'sh7FFF, 16'sh8000, 16'sh8000};
    launch(t); expect_scan_then_hold("sat"); drain("sat");
    check("sat.margin_k", 32'(margin), 32'h7FFF);

    for (int it = 0; it < 30; it++) begin
      launch(rand_vec());
      expect_scan_then_hold("rnd");
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(negedge clk);
        check("rnd.hold_v", 32'(out_valid), 32'd1);
        check("rnd.hold_max", 32'(max_score), 32'(e_max));
      end
      drain("rnd");
    end

    // Start during SCAN and HOLD with backpressure.
    t = '{16'sh0100, 16'sh0300, 16'shFF00};
    launch(t);
    scores = '{16'sh0700, 16'sh0000, 16'sh0000};
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("ovr.scan_set", 32'(overrun), 32'd1);
    @(negedge clk);
    check("ovr.valid", 32'(out_valid), 32'd1);
    check("ovr.idx", 32'(class_idx), 32'(e_idx));
    check("ovr.margin", 32'(margin), 32'(e_mg));
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("ovr.clr1", 32'(overrun), 32'd0);
    for (int c = 0; c < 5; c++) begin
      start = (c == 1);
      @(negedge clk);
      start = 1'b0;
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.idx", 32'(class_idx), 32'(e_idx));
      check("bp.max", 32'(max_score), 32'(e_max));
      check("bp.margin", 32'(margin), 32'(e_mg));
    end
    check("bp.overrun", 32'(overrun), 32'd1);
    start         = 1'b1;
    clear_overrun = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    clear_overrun = 1'b0;
    check("ovr.set_wins", 32'(overrun), 32'd1);
    drain("bp");
    repeat (2) @(negedge clk);
    check("bp.single", 32'(out_valid), 32'd0);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("ovr.clr2", 32'(overrun), 32'd0);

    // Back-to-back: start together with the completing transfer.
    t = '{16'sh0400, 16'sh0100, 16'sh0200};
    launch(t); expect_scan_then_hold("b2b1");
    out_ready = 1'b1;
    t = '{16'sh0000, 16'sh0000, 16'sh0500};
    launch(t);
    out_ready = 1'b0;
    expect_scan_then_hold("b2b2");
    check("b2b.idx_k", 32'(class_idx), 32'd2);
    check("b2b.overrun", 32'(overrun), 32'd0);
    drain("b2b");

    // Asynchronous reset one cycle into the scan.
    t = '{16'sh0100, 16'sh0300, 16'shFF00};
    launch(t);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.idx", 32'(class_idx), 32'd0);
    check("arst.max", 32'(max_score), 32'd0);
    check("arst.margin", 32'(margin), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    t = '{16'sh0050, 16'shFFF0, 16'sh0060};
    launch(t); expect_scan_then_hold("post"); drain("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
